// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Load/store sequencer feeding the read_data load-extract stage. Takes one
//   request at a time from the pipeline and drives a word-addressed data
//   memory. An access that straddles a 32-bit word boundary is split into a
//   LO and a HI word transaction. The response is a word plus an address whose
//   low bits let read_data pick the byte or halfword without further shifting.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we/addr/size/wdata      request: store flag, byte address,
//                               size (00 word, 01 byte, 10 half, 11 word),
//                               right-justified store data
//   mem_req/mem_gnt             memory transaction request / accept
//   mem_we/addr/wmask/wdata     transaction payload (word address, lane data)
//   mem_rvalid/mem_rdata        transaction completion and read word
//   resp_valid                  one-cycle completion pulse
//   ReadData/AddrOut            result word and address for read_data
//   resp_err                    completion was a timeout (valid with resp_valid)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request
// REQ_LO  | first (or only) word transaction requested, waiting for gnt
// WAIT_LO | first transaction granted, waiting for rvalid
// REQ_HI  | second word of a split access requested, waiting for gnt
// WAIT_HI | second transaction granted, waiting for rvalid
// RESP    | result presented for one cycle
module mem_access_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       ReadData,
  output logic [ADDR_W-1:0] AddrOut,
  output logic              resp_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [31:0]         wdata_q;
  logic [31:0]         lo_q, lo_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addrout_q, addrout_d;
  logic                err_q, err_d;

  logic                accept;
  logic [1:0]          off;
  logic                split;
  logic [3:0]          base_mask;
  logic [7:0]          mask8;
  logic [63:0]         data64;
  logic [63:0]         joined;
  logic [ADDR_W-1:0]   lo_waddr;
  logic [ADDR_W-1:0]   hi_waddr;

  assign accept   = req_valid && (state_q == IDLE);
  assign off      = addr_q[1:0];
  // Word (or size 11) splits on any misalignment; halfword only at offset 3.
  assign split    = (size_q == 2'b10) ? (off == 2'b11)
                  : (size_q == 2'b01) ? 1'b0
                  : (off != 2'b00);
  assign lo_waddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign hi_waddr = lo_waddr + ADDR_W'(4);

  always_comb begin
    case (size_q)
      2'b01:   base_mask = 4'b0001;
      2'b10:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Lanes spill into the upper half when the access crosses the word.
  assign mask8  = {4'b0000, base_mask} << off;
  assign data64 = {32'h0, wdata_q} << {off, 3'b000};
  // HI word arrives on mem_rdata in the same cycle the result is formed.
  assign joined = {mem_rdata, lo_q} >> {off, 3'b000};

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    addrout_d  = addrout_q;
    err_d      = err_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wmask  = 4'b0000;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = REQ_LO;
      end

      REQ_LO: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = lo_waddr;
        if (we_q) begin
          mem_wmask = mask8[3:0];
          mem_wdata = data64[31:0];
        end
        if (mem_gnt) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_LOAD;
        end
      end

      WAIT_LO: begin
        if (mem_rvalid) begin
          lo_d = mem_rdata;
          if (split) begin
            state_d = REQ_HI;
          end else begin
            state_d   = RESP;
            rdata_d   = we_q ? 32'h0 : mem_rdata;
            addrout_d = addr_q;
            err_d     = 1'b0;
          end
        end else if (cnt_q == '0) begin
          state_d   = RESP;
          rdata_d   = 32'h0;
          addrout_d = split ? lo_waddr : addr_q;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      REQ_HI: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = hi_waddr;
        if (we_q) begin
          mem_wmask = mask8[7:4];
          mem_wdata = data64[63:32];
        end
        if (mem_gnt) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_LOAD;
        end
      end

      WAIT_HI: begin
        if (mem_rvalid) begin
          state_d   = RESP;
          rdata_d   = we_q ? 32'h0 : joined[31:0];
          addrout_d = lo_waddr;
          err_d     = 1'b0;
        end else if (cnt_q == '0) begin
          state_d   = RESP;
          rdata_d   = 32'h0;
          addrout_d = lo_waddr;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= 2'b00;
      wdata_q   <= 32'h0;
      lo_q      <= 32'h0;
      cnt_q     <= '0;
      rdata_q   <= 32'h0;
      addrout_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      addrout_q <= addrout_d;
      err_q     <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
    end
  end

  assign ReadData = rdata_q;
  assign AddrOut  = addrout_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int ADDR_W   = 32;
  localparam int MAX_WAIT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              resp_valid;
  logic [31:0]       ReadData;
  logic [ADDR_W-1:0] AddrOut;
  logic              resp_err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .ReadData(ReadData), .AddrOut(AddrOut),
    .resp_err(resp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        split;
    logic [31:0] alo;
    logic [31:0] ahi;
    logic [3:0]  mlo;
    logic [3:0]  mhi;
    logic [31:0] dlo;
    logic [31:0] dhi;
    logic [31:0] rd;
    logic [31:0] ao;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(
    input logic we, input logic [31:0] addr, input logic [1:0] size,
    input logic [31:0] wdata, input logic [31:0] lo, input logic [31:0] hi,
    input logic split, input logic [31:0] alo, input logic [31:0] ahi,
    input logic [3:0] mlo, input logic [3:0] mhi,
    input logic [31:0] dlo, input logic [31:0] dhi,
    input logic [31:0] rd, input logic [31:0] ao);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.wdata = wdata;
    v.lo = lo; v.hi = hi; v.split = split; v.alo = alo; v.ahi = ahi;
    v.mlo = mlo; v.mhi = mhi; v.dlo = dlo; v.dhi = dhi; v.rd = rd; v.ao = ao;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    check($sformatf("v%0d_ready", i), req_ready, 1);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_size = v.size; req_wdata = v.wdata;
    step();
    req_valid = 1'b0;
    check($sformatf("v%0d_lo_req", i), mem_req, 1);
    check($sformatf("v%0d_lo_we", i), mem_we, v.we);
    check($sformatf("v%0d_lo_addr", i), mem_addr, v.alo);
    check($sformatf("v%0d_lo_mask", i), mem_wmask, v.mlo);
    if (v.we) check($sformatf("v%0d_lo_wdata", i), mem_wdata, v.dlo);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check($sformatf("v%0d_wait_noreq", i), mem_req, 0);
    mem_rvalid = 1'b1; mem_rdata = v.lo;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    if (v.split) begin
      check($sformatf("v%0d_hi_noresp", i), resp_valid, 0);
      check($sformatf("v%0d_hi_req", i), mem_req, 1);
      check($sformatf("v%0d_hi_addr", i), mem_addr, v.ahi);
      check($sformatf("v%0d_hi_mask", i), mem_wmask, v.mhi);
      if (v.we) check($sformatf("v%0d_hi_wdata", i), mem_wdata, v.dhi);
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = v.hi;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
    end
    check($sformatf("v%0d_resp_valid", i), resp_valid, 1);
    check($sformatf("v%0d_resp_err", i), resp_err, 0);
    check($sformatf("v%0d_ReadData", i), ReadData, v.rd);
    check($sformatf("v%0d_AddrOut", i), AddrOut, v.ao);
    step();
    check($sformatf("v%0d_resp_pulse", i), resp_valid, 0);
    check($sformatf("v%0d_hold_rd", i), ReadData, v.rd);
  endtask

  initial begin
    int n;
    logic [31:0] held_addr;

    //        we    addr          sz     wdata         lo            hi            spl  alo           ahi           mlo      mhi      dlo           dhi           rd            ao
    vecs[0]  = mk(1'b0, 32'h0000_0100, 2'b00, 32'h0,        32'ha5b4c3d2, 32'h0,        1'b0, 32'h100,      32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'ha5b4c3d2, 32'h100);
    vecs[1]  = mk(1'b1, 32'h0000_0203, 2'b01, 32'h000000ee, 32'h0,        32'h0,        1'b0, 32'h200,      32'h0,        4'b1000, 4'b0000, 32'hee000000, 32'h0,        32'h0,        32'h203);
    vecs[2]  = mk(1'b0, 32'h0000_0101, 2'b00, 32'h0,        32'h44332211, 32'h88776655, 1'b1, 32'h100,      32'h104,      4'b0000, 4'b0000, 32'h0,        32'h0,        32'h55443322, 32'h100);
    vecs[3]  = mk(1'b1, 32'h0000_0103, 2'b10, 32'h0000beef, 32'h0,        32'h0,        1'b1, 32'h100,      32'h104,      4'b1000, 4'b0001, 32'hef000000, 32'h000000be, 32'h0,        32'h100);
    vecs[4]  = mk(1'b0, 32'h0000_0102, 2'b10, 32'h0,        32'hdeadbeef, 32'h0,        1'b0, 32'h100,      32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'hdeadbeef, 32'h102);
    vecs[5]  = mk(1'b0, 32'h0000_0103, 2'b00, 32'h0,        32'h44332211, 32'h88776655, 1'b1, 32'h100,      32'h104,      4'b0000, 4'b0000, 32'h0,        32'h0,        32'h77665544, 32'h100);
    vecs[6]  = mk(1'b0, 32'h0000_0003, 2'b01, 32'h0,        32'h11223344, 32'h0,        1'b0, 32'h0,        32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        32'h11223344, 32'h3);
    vecs[7]  = mk(1'b1, 32'h0000_0202, 2'b00, 32'h12345678, 32'h0,        32'h0,        1'b1, 32'h200,      32'h204,      4'b1100, 4'b0011, 32'h56780000, 32'h00001234, 32'h0,        32'h200);
    vecs[8]  = mk(1'b0, 32'hffff_fffe, 2'b00, 32'h0,        32'haabbccdd, 32'h11223344, 1'b1, 32'hfffffffc, 32'h00000000, 4'b0000, 4'b0000, 32'h0,        32'h0,        32'h3344aabb, 32'hfffffffc);
    vecs[9]  = mk(1'b1, 32'h0000_0204, 2'b11, 32'hcafef00d, 32'h0,        32'h0,        1'b0, 32'h204,      32'h0,        4'b1111, 4'b0000, 32'hcafef00d, 32'h0,        32'h0,        32'h204);
    vecs[10] = mk(1'b1, 32'h0000_0101, 2'b10, 32'h0000abcd, 32'h0,        32'h0,        1'b0, 32'h100,      32'h0,        4'b0110, 4'b0000, 32'h00abcd00, 32'h0,        32'h0,        32'h101);

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_size = 2'b00; req_wdata = 32'h0; mem_gnt = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    step(); step();

    check("rst_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_ReadData", ReadData, 0);
    check("rst_AddrOut", AddrOut, 0);
    check("rst_resp_err", resp_err, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // gnt and rvalid together in REQ_LO: that rvalid must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'b00;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hdeaddead;
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    check("same_cyc_noresp", resp_valid, 0);
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check("same_cyc_resp", resp_valid, 1);
    check("same_cyc_rd", ReadData, 32'h12345678);
    step();

    // Delayed grant, then timeout in WAIT_LO.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'b00;
    step();
    held_addr = mem_addr;
    req_addr = 32'h300;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("to_gntwait_req%0d", k), mem_req, 1);
      check($sformatf("to_gntwait_addr%0d", k), mem_addr, 32'h100);
      check($sformatf("to_gntwait_stable%0d", k), mem_addr, held_addr);
      check($sformatf("to_gntwait_notready%0d", k), req_ready, 0);
      step();
    end
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin
      n++;
      step();
    end
    check("to_wait_cycles", n, MAX_WAIT);
    check("to_resp_valid", resp_valid, 1);
    check("to_resp_err", resp_err, 1);
    check("to_ReadData", ReadData, 0);
    check("to_no_hi_req", mem_req, 0);
    step();
    check("to_pulse", resp_valid, 0);
    check("to_err_clears", resp_err, 0);

    // Reset in WAIT_HI, followed by a late rvalid.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h101; req_size = 2'b00;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h44332211; step(); mem_rvalid = 1'b0;
    check("rstmid_in_req_hi", mem_addr, 32'h104);
    mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid_ready", req_ready, 1);
    check("rstmid_mem_req", mem_req, 0);
    check("rstmid_noresp", resp_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h88776655;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rstmid_late_noresp%0d", k), resp_valid, 0);
      check($sformatf("rstmid_late_ready%0d", k), req_ready, 1);
      step();
    end

    // Still functional after the mid-operation reset.
    run_vec(0, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer directly upstream of the load-extract stage (`read_data`).
- Accepts one load or store request from the pipeline and drives a word-addressed data memory.
- Splits accesses that cross a 32-bit word boundary into two memory transactions.
- Returns a word plus an address whose low bits let `read_data` select the requested byte or halfword unchanged.

Parameters:
- ADDR_W, 32, byte-address width.
- MAX_WAIT, 15, maximum cycles to wait for mem_rvalid before flagging a timeout.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address.
- req_size  input  2  00 word, 01 byte, 10 halfword; 11 is treated as word.
- req_wdata  input  32  store data, right-justified.
- mem_req  output  1  memory transaction request.
- mem_gnt  input  1  memory accepted the transaction this cycle.
- mem_we  output  1  write transaction.
- mem_addr  output  ADDR_W  word address, low 2 bits always 0.
- mem_wmask  output  4  byte write enables.
- mem_wdata  output  32  write data, lane-aligned.
- mem_rvalid  input  1  transaction complete; mem_rdata valid (writes also ack).
- mem_rdata  input  32  read word.
- resp_valid  output  1  one-cycle completion pulse.
- ReadData  output  32  word for `read_data`.
- AddrOut  output  ADDR_W  address for `read_data`.
- resp_err  output  1  timeout occurred; valid with resp_valid.

Behaviour:
- Reset values: req_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wmask=0, mem_wdata=0, resp_valid=0, ReadData=0, AddrOut=0, resp_err=0; state IDLE.
- Split rule: off=addr[1:0]. A split is needed when word and off≠0, or halfword and off=3. Byte accesses never split.
- States: IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP.
- IDLE:
  - req_ready=1 only here.
  - req_valid&&req_ready latches we/addr/size/wdata and moves to REQ_LO.
- REQ_LO:
  - mem_req=1, mem_addr={addr[31:2],00}.
  - Hold all memory outputs stable until mem_gnt; on gnt go to WAIT_LO.
- WAIT_LO:
  - On mem_rvalid, latch rdata into lo, then go to REQ_HI if split, else RESP.
- REQ_HI/WAIT_HI:
  - Same as LO with mem_addr = lo word address + 4 (wraps modulo 2^ADDR_W).
  - Latch rdata into hi.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Minimum latency from accept to resp_valid: 3 cycles (gnt and rvalid each the same cycle they are first possible). Split accesses add 2 cycles.
- Store mask and data:
  - 8-bit mask m = (word 1111, half 0011, byte 0001) << off.
  - 64-bit data d = {32'b0, wdata} << (8*off).
  - LO transaction uses m[3:0] and d[31:0]; HI transaction uses m[7:4] and d[63:32].
  - Loads: mem_wmask=0.
- Load result:
  - Unsplit: ReadData=lo, AddrOut=latched addr.
  - Split: ReadData = ({hi,lo} >> 8*off)[31:0], AddrOut={addr[31:2],00}.
- ReadData/AddrOut are registered, hold until the next RESP, and are also updated for stores (ReadData=0).
- Timeout:
  - Counter counts cycles in WAIT_*. When it reaches MAX_WAIT, go to RESP with resp_err=1 and ReadData=0; the HI access is skipped.
  - resp_err is otherwise 0.
- A request arriving while not IDLE is not accepted (req_ready=0); the requester holds it.
- mem_rvalid outside WAIT_* (late or stray) is ignored.
- mem_gnt and mem_rvalid in the same cycle while in REQ_*: the gnt is taken, and that rvalid is ignored.
- Reset mid-operation: the next cycle is IDLE, mem_req=0, no resp_valid; a pending memory response is discarded.

Test Plan:
- Aligned word load, addr 0x100, mem_rdata 0xa5b4c3d2 -> one mem access at 0x100, wmask 0, resp_valid once with ReadData=0xa5b4c3d2, AddrOut=0x100.
- Byte store 0x000000ee at addr 0x203 -> single access at 0x200, wmask 1000, wdata 0xee000000.
- Misaligned word load at 0x101, lo=0x44332211, hi=0x88776655 -> accesses 0x100 then 0x104, ReadData=0x55443322, AddrOut=0x100.
- Misaligned half store 0xbeef at 0x103 -> access 0x100 with mask 1000, wdata 0xef000000, then 0x104 with mask 0001, wdata 0x000000be.
- mem_gnt delayed 3 cycles, then no mem_rvalid for MAX_WAIT cycles -> mem outputs stable while waiting for gnt, then resp_valid with resp_err=1, ReadData=0.
- Reset asserted in WAIT_HI with a late mem_rvalid one cycle later -> IDLE, req_ready=1, no resp_valid, the late rvalid is ignored.
